// File: rtl/alarm_scheduler_if.sv
//==============================================================================
// Module      : alarm_scheduler_if
// Description : Control/status bundle between the time services, the alarm
//               scheduler and the alarm mini-game.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface alarm_scheduler_if #(
  parameter int N_SLOTS = 4
);
  localparam int SW = $clog2(N_SLOTS);

  logic          enable;
  logic [15:0]   current;
  logic          minute_tick;
  logic          wr_en;
  logic [SW-1:0] wr_slot;
  logic [15:0]   wr_time;
  logic          wr_arm;
  logic          push_m;
  logic          game_done;
  logic          ring;
  logic          game_start;
  logic [SW-1:0] active_slot;
  logic [2:0]    state;
  logic [1:0]    snooze_cnt;
  logic          missed;

  modport master (
    output enable, current, minute_tick, wr_en, wr_slot, wr_time, wr_arm,
           push_m, game_done,
    input  ring, game_start, active_slot, state, snooze_cnt, missed
  );

  modport slave (
    input  enable, current, minute_tick, wr_en, wr_slot, wr_time, wr_arm,
           push_m, game_done,
    output ring, game_start, active_slot, state, snooze_cnt, missed
  );
endinterface

`default_nettype wire

// File: rtl/alarm_scheduler.sv
//==============================================================================
// Module      : alarm_scheduler
// Description : Multi-slot BCD alarm scheduler: watch, ring, game dismissal,
//               snooze with BCD wrap and missed-alarm tracking.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alarm_scheduler #(
  parameter int N_SLOTS      = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  alarm_scheduler_if.slave bus
);
  localparam int SW   = $clog2(N_SLOTS);
  localparam int c_TW = $clog2(RING_TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(RING_TIMEOUT - 1);
  localparam logic [1:0]      c_SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WATCH  = 3'd1,
    S_RING   = 3'd2,
    S_GAME   = 3'd3,
    S_SNOOZE = 3'd4
  } t_state;

  t_state            r_state, w_next;
  logic [15:0]       r_time [N_SLOTS];
  logic [N_SLOTS-1:0] r_armed, r_fired;
  logic [N_SLOTS-1:0] w_eq, w_match;
  logic [c_TW-1:0]   r_tick, w_tick_nxt;
  logic [1:0]        r_snz, w_snz_nxt;
  logic [15:0]       r_target, w_target_nxt;
  logic [SW-1:0]     r_active, w_active_nxt, w_win;
  logic              r_missed, w_missed_nxt;
  logic              r_game_start;
  logic              w_any, w_fire;

  // Adds SNOOZE_MIN to a BCD HH:MM value, wrapping 59->00 and 23->00.
  function automatic logic [15:0] f_bcd_add(input logic [15:0] t);
    logic [6:0] m, m10, m1;
    logic [4:0] h, h10, h1;
    m = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(SNOOZE_MIN);
    h = 5'(t[15:12]) * 5'd10 + 5'(t[11:8]);
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = h + 5'd1;
    end
    if (h == 5'd24) h = 5'd0;
    m10 = m / 7'd10;
    m1  = m - m10 * 7'd10;
    h10 = h / 5'd10;
    h1  = h - h10 * 5'd10;
    return {h10[3:0], h1[3:0], m10[3:0], m1[3:0]};
  endfunction

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    assign w_eq[gi]    = (r_time[gi] == bus.current);
    assign w_match[gi] = r_armed[gi] & w_eq[gi] & ~r_fired[gi];
  end

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_any = 1'b1;
        w_win = SW'(i);
      end
    end
  end

  // Slot storage; fired bits drop as soon as the clock leaves the slot's minute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) r_time[i] <= '0;
      r_armed <= '0;
      r_fired <= '0;
    end else begin
      r_fired <= r_fired & w_eq;
      if (w_fire) r_fired[w_win] <= 1'b1;
      if (bus.wr_en) begin
        r_time[bus.wr_slot]  <= bus.wr_time;
        r_armed[bus.wr_slot] <= bus.wr_arm;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_snz        <= '0;
      r_target     <= '0;
      r_active     <= '0;
      r_missed     <= 1'b0;
      r_game_start <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_tick       <= w_tick_nxt;
      r_snz        <= w_snz_nxt;
      r_target     <= w_target_nxt;
      r_active     <= w_active_nxt;
      r_missed     <= w_missed_nxt;
      r_game_start <= (w_next == S_GAME) && (r_state != S_GAME);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_tick_nxt   = r_tick;
    w_snz_nxt    = r_snz;
    w_target_nxt = r_target;
    w_active_nxt = r_active;
    w_missed_nxt = r_missed & ~bus.wr_en;
    w_fire       = 1'b0;
    if (!bus.enable) begin
      w_next       = S_IDLE;
      w_tick_nxt   = '0;
      w_snz_nxt    = '0;
      w_active_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_WATCH;
        S_WATCH: begin
          if (w_any) begin
            w_fire       = 1'b1;
            w_active_nxt = w_win;
            w_tick_nxt   = '0;
            w_next       = S_RING;
          end
        end
        S_RING: begin
          // A dismiss request beats a timeout landing on the same edge.
          if (bus.push_m) begin
            w_next = S_GAME;
          end else if (bus.minute_tick) begin
            w_tick_nxt = r_tick + 1'b1;
            if (r_tick == c_TICK_LAST) begin
              if (r_snz < c_SNZ_MAX) begin
                w_next       = S_SNOOZE;
                w_snz_nxt    = r_snz + 2'd1;
                w_target_nxt = f_bcd_add(bus.current);
              end else begin
                w_missed_nxt = 1'b1;
                w_snz_nxt    = '0;
                w_next       = S_WATCH;
              end
            end
          end
        end
        S_GAME: begin
          if (bus.game_done) begin
            w_next    = S_WATCH;
            w_snz_nxt = '0;
          end
        end
        S_SNOOZE: begin
          if (bus.current == r_target) begin
            w_next     = S_RING;
            w_tick_nxt = '0;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign bus.ring        = (r_state == S_RING);
  assign bus.game_start  = r_game_start;
  assign bus.active_slot = r_active;
  assign bus.state       = r_state;
  assign bus.snooze_cnt  = r_snz;
  assign bus.missed      = r_missed;

endmodule

`default_nettype wire
